// File: rtl/cordic_seq_pkg.sv
// Shared encodings and helpers for the CORDIC operand sequencer.
package cordic_seq_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StF      = 3'd1;
  localparam logic [2:0] StE1     = 3'd2;
  localparam logic [2:0] StE2     = 3'd3;
  localparam logic [2:0] StGo     = 3'd4;
  localparam logic [2:0] StResult = 3'd5;

  // Functions 0, 1 and 7 take two operands.
  localparam logic [8:0] DefaultTwoOpMask = 9'b010000011;

  // Never returns 0, so a depth-1 table still gets a 1-bit address.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/cordic_op_sequencer_phase_timer.sv
// Dwell counter for one sequencer phase: runs 0..WAIT_CNT, flags the last cycle.
module phase_timer
  import cordic_seq_pkg::*;
#(
  parameter int unsigned WAIT_CNT = 70
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = clog2(WAIT_CNT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = (cnt_q == CW'(WAIT_CNT));

endmodule

// File: rtl/cordic_op_sequencer.sv
// Walks a loadable operand table over every function code and drives the
// CORDIC sw_in/st switch interface one phase at a time.
module cordic_op_sequencer
  import cordic_seq_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned N_OPS    = 8,
  parameter int unsigned N_FUNC   = 9,
  parameter int unsigned WAIT_CNT = 70,
  parameter int unsigned FW       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      loop_en,
  input  logic [N_FUNC-1:0]         two_op_mask,
  input  logic                      tbl_we,
  input  logic [clog2(N_OPS)-1:0]   tbl_addr,
  input  logic [2*W-1:0]            tbl_din,
  output logic [W-1:0]              sw_out,
  output logic                      st,
  output logic [FW-1:0]             func_idx,
  output logic [clog2(N_OPS)-1:0]   op_idx,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned AW = clog2(N_OPS);
  localparam int unsigned NF = 2 ** FW;

  logic [2:0]     state_q, state_d;
  logic [FW-1:0]  func_q, func_d;
  logic [AW-1:0]  op_q, op_d;
  logic [W-1:0]   sw_q, sw_d;
  logic           done_q, done_d;
  logic [2*W-1:0] tbl_q [N_OPS];

  logic           expired;
  logic           running;
  logic           two_op;
  logic           last_op;
  logic           last_func;
  logic [NF-1:0]  mask_ext;

  assign running   = (state_q != StIdle);
  assign mask_ext  = NF'(two_op_mask);
  assign two_op    = mask_ext[func_q];
  assign last_op   = (op_q == AW'(N_OPS - 1));
  assign last_func = (func_q == FW'(N_FUNC - 1));

  phase_timer #(
    .WAIT_CNT(WAIT_CNT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!running || expired || abort),
    .en     (running),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    op_d    = op_q;
    sw_d    = sw_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else if (!running) begin
      if (start) begin
        state_d = StF;
        func_d  = '0;
        op_d    = '0;
      end
    end else if (expired) begin
      unique case (state_q)
        StF:  state_d = StE1;
        StE1: state_d = two_op ? StE2 : StGo;
        StE2: state_d = StGo;
        StGo: state_d = StResult;
        StResult: begin
          if (!last_op) begin
            op_d    = op_q + AW'(1);
            state_d = StF;
          end else if (!last_func) begin
            op_d    = '0;
            func_d  = func_q + FW'(1);
            state_d = StF;
          end else begin
            done_d  = 1'b1;
            op_d    = '0;
            func_d  = '0;
            state_d = loop_en ? StF : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // sw_out is loaded only on entry to a presenting phase; GO/RESULT/IDLE hold it.
    if (state_d != state_q) begin
      case (state_d)
        StF:     sw_d = W'(func_d);
        StE1:    sw_d = tbl_q[op_d][2*W-1:W];
        StE2:    sw_d = tbl_q[op_d][W-1:0];
        default: sw_d = sw_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      func_q  <= '0;
      op_q    <= '0;
      sw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      op_q    <= op_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
    end
  end

  // Table is deliberately unreset.
  always_ff @(posedge clk) begin
    if (tbl_we && !running) begin
      tbl_q[tbl_addr] <= tbl_din;
    end
  end

  assign sw_out   = sw_q;
  assign st       = running && expired && !abort;
  assign func_idx = func_q;
  assign op_idx   = op_q;
  assign busy     = running;
  assign done     = done_q;

endmodule

// File: tb/tb_cordic_op_sequencer.sv
// Bench for cordic_op_sequencer: a 1x1 instance for cycle-exact phase checks
// and a full-size instance checked against an expected-phase scoreboard.
module tb_cordic_op_sequencer;
  import cordic_seq_pkg::*;

  localparam int unsigned WC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: one entry, one function.
  logic        start_a = 1'b0, abort_a = 1'b0, we_a = 1'b0;
  logic [0:0]  mask_a = 1'b1;
  logic [0:0]  addr_a = 1'b0;
  logic [31:0] din_a = '0;
  logic [15:0] sw_a;
  logic        st_a, busy_a, done_a;
  logic [3:0]  func_a;
  logic [0:0]  op_a;

  // Instance B: default geometry.
  logic        start_b = 1'b0, abort_b = 1'b0, loop_b = 1'b0, we_b = 1'b0;
  logic [8:0]  mask_b = DefaultTwoOpMask;
  logic [2:0]  addr_b = '0;
  logic [31:0] din_b = '0;
  logic [15:0] sw_b;
  logic        st_b, busy_b, done_b;
  logic [3:0]  func_b;
  logic [2:0]  op_b;

  cordic_op_sequencer #(.W(16), .N_OPS(1), .N_FUNC(1), .WAIT_CNT(WC), .FW(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .loop_en(1'b0),
    .two_op_mask(mask_a), .tbl_we(we_a), .tbl_addr(addr_a), .tbl_din(din_a),
    .sw_out(sw_a), .st(st_a), .func_idx(func_a), .op_idx(op_a), .busy(busy_a), .done(done_a)
  );

  cordic_op_sequencer #(.W(16), .N_OPS(8), .N_FUNC(9), .WAIT_CNT(WC), .FW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .loop_en(loop_b),
    .two_op_mask(mask_b), .tbl_we(we_b), .tbl_addr(addr_b), .tbl_din(din_b),
    .sw_out(sw_b), .st(st_b), .func_idx(func_b), .op_idx(op_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] op1f(input int e);
    return 16'(16'h1100 + e);
  endfunction

  function automatic logic [15:0] op2f(input int e);
    return 16'(16'hA000 + 16'h0101 * e);
  endfunction

  // Cycle-exact expectations for instance A; cyc counts from the edge that samples start.
  typedef struct {
    logic        mask;
    int          cyc;
    logic [15:0] sw;
    logic        st;
    logic        done;
    logic        busy;
  } vec_t;
  vec_t vecs[$];

  typedef struct packed {
    logic [3:0]  f;
    logic [2:0]  o;
    logic [15:0] sw;
  } sb_t;
  sb_t exp_q[$];

  task automatic run_single(input logic mask, input int exp_st);
    int nst = 0;
    mask_a = mask;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (st_a) nst++;
      foreach (vecs[i]) begin
        if (vecs[i].mask == mask && vecs[i].cyc == cyc) begin
          check($sformatf("a_sw m%0d c%0d", mask, cyc), 32'(sw_a), 32'(vecs[i].sw));
          check($sformatf("a_st m%0d c%0d", mask, cyc), 32'(st_a), 32'(vecs[i].st));
          check($sformatf("a_done m%0d c%0d", mask, cyc), 32'(done_a), 32'(vecs[i].done));
          check($sformatf("a_busy m%0d c%0d", mask, cyc), 32'(busy_a), 32'(vecs[i].busy));
        end
      end
      @(negedge clk);
    end
    check($sformatf("a_st_count m%0d", mask), 32'(nst), 32'(exp_st));
  endtask

  task automatic run_sweep(input bit disturb, input bit looping);
    int  nst = 0;
    bit  got_done = 0;
    sb_t r;
    exp_q.delete();
    for (int f = 0; f < 9; f++) begin
      for (int e = 0; e < 8; e++) begin
        r.f = 4'(f);
        r.o = 3'(e);
        r.sw = 16'(f);     exp_q.push_back(r);
        r.sw = op1f(e);    exp_q.push_back(r);
        if (DefaultTwoOpMask[f]) begin
          r.sw = op2f(e);  exp_q.push_back(r);
        end
        exp_q.push_back(r);
        exp_q.push_back(r);
      end
    end
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_busy_first", 32'(busy_b), 32'd1);
    for (int cyc = 1; cyc <= 2000 && !got_done; cyc++) begin
      if (st_b) begin
        nst++;
        if (exp_q.size() == 0) begin
          check("b_sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          r = exp_q.pop_front();
          check($sformatf("b_func st%0d", nst), 32'(func_b), 32'(r.f));
          check($sformatf("b_op st%0d", nst), 32'(op_b), 32'(r.o));
          check($sformatf("b_sw st%0d", nst), 32'(sw_b), 32'(r.sw));
        end
      end
      if (done_b) got_done = 1;
      if (disturb && cyc == 6) begin
        we_b = 1'b1; addr_b = 3'd3; din_b = 32'hDEAD_BEEF; start_b = 1'b1;
      end
      if (disturb && cyc == 7) begin
        we_b = 1'b0; start_b = 1'b0;
      end
      if (!got_done) @(negedge clk);
    end
    check("b_sweep_done", 32'(got_done), 32'd1);
    check("b_st_count", 32'(nst), 32'd312);
    check("b_sb_left", 32'(exp_q.size()), 32'd0);
    check("b_busy_at_done", 32'(busy_b), 32'(looping));
    if (looping) begin
      check("b_loop_func", 32'(func_b), 32'd0);
      check("b_loop_op", 32'(op_b), 32'd0);
      check("b_loop_sw", 32'(sw_b), 32'd0);
    end
    @(negedge clk);
    check("b_done_pulse", 32'(done_b), 32'd0);
  endtask

  initial begin
    bit          found;
    logic [15:0] held;

    // mask, cyc, sw, st, done, busy
    vecs.push_back('{1'b1,  1, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1,  4, 16'h0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1,  5, 16'h4000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1,  8, 16'h4000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1,  9, 16'h2A9B, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 12, 16'h2A9B, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 13, 16'h2A9B, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 16, 16'h2A9B, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 20, 16'h2A9B, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 21, 16'h2A9B, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 22, 16'h2A9B, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0,  1, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0,  8, 16'h4000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0,  9, 16'h4000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 12, 16'h4000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16, 16'h4000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 17, 16'h4000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 18, 16'h4000, 1'b0, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sw", 32'(sw_b), 32'd0);
    check("rst_st", 32'(st_b), 32'd0);
    check("rst_busy", 32'(busy_b), 32'd0);
    check("rst_done", 32'(done_b), 32'd0);
    check("rst_func", 32'(func_b), 32'd0);
    check("rst_op", 32'(op_b), 32'd0);
    check("rst_a_sw", 32'(sw_a), 32'd0);

    // Load both tables.
    we_a = 1'b1; addr_a = 1'b0; din_a = {16'h4000, 16'h2A9B};
    for (int e = 0; e < 8; e++) begin
      we_b = 1'b1; addr_b = 3'(e); din_b = {op1f(e), op2f(e)};
      @(negedge clk);
      we_a = 1'b0;
    end
    we_b = 1'b0;

    run_single(1'b1, 5);
    run_single(1'b0, 4);

    // Abort coinciding with the final st: abort wins, no done.
    mask_a = 1'b1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (19) @(negedge clk);
    abort_a = 1'b1;
    #1 check("a_abort_final_st", 32'(st_a), 32'd0);
    @(negedge clk) abort_a = 1'b0;
    check("a_abort_final_done", 32'(done_a), 32'd0);
    check("a_abort_final_busy", 32'(busy_a), 32'd0);

    run_sweep(1'b0, 1'b0);

    // Abort during E1 of entry 2.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (op_b == 3'd2 && sw_b == op1f(2)) found = 1;
      else @(negedge clk);
    end
    check("b_abort_wait", 32'(found), 32'd1);
    held = sw_b;
    abort_b = 1'b1;
    #1 check("b_abort_st", 32'(st_b), 32'd0);
    @(negedge clk) abort_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b_abort_busy %0d", i), 32'(busy_b), 32'd0);
      check($sformatf("b_abort_done %0d", i), 32'(done_b), 32'd0);
      check($sformatf("b_abort_sw %0d", i), 32'(sw_b), 32'(op1f(2)));
      @(negedge clk);
    end
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_restart_busy", 32'(busy_b), 32'd1);
    check("b_restart_func", 32'(func_b), 32'd0);
    check("b_restart_op", 32'(op_b), 32'd0);
    check("b_restart_sw", 32'(sw_b), 32'd0);
    abort_b = 1'b1;
    @(negedge clk) abort_b = 1'b0;

    // Loop mode, with a table write and a start attempted mid-sweep.
    loop_b = 1'b1;
    run_sweep(1'b1, 1'b1);
    loop_b = 1'b0;
    abort_b = 1'b1;
    @(negedge clk) abort_b = 1'b0;
    check("b_loop_abort_busy", 32'(busy_b), 32'd0);

    // Asynchronous reset in the F phase of function 1.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (func_b == 4'd1) found = 1;
      else @(negedge clk);
    end
    check("b_rst_wait", 32'(found), 32'd1);
    check("b_rst_pre_sw", 32'(sw_b), 32'd1);
    rst = 1'b1;
    #1;
    check("b_rst_sw", 32'(sw_b), 32'd0);
    check("b_rst_st", 32'(st_b), 32'd0);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_done", 32'(done_b), 32'd0);
    check("b_rst_func", 32'(func_b), 32'd0);
    check("b_rst_op", 32'(op_b), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("b_rst_idle", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_op_sequencer.md
# cordic_op_sequencer

Synthesizable, parametrised operand sequencer that drives the CORDIC top-level switch interface (`sw_in`/`st`). It walks a loadable operand table across every function code and presents, per operation, the function code, operand 1, an optional operand 2, GO and RESULT phases, each held for a programmable dwell and closed by a one-cycle `st` strobe. Compared with the fixed bench sequencer it generalises operand width, table depth, function count and per-function operand count, and adds abort and loop modes. It sits between a table loader (UART or bench) and the CORDIC `Top`.

## Interface
- `W`, 16, operand and `sw_out` width.
- `N_OPS`, 8, operand table depth.
- `N_FUNC`, 9, number of function codes swept.
- `WAIT_CNT`, 70, dwell count per phase; must be ≥1.
- `FW`, 4, function code width; requires 2^FW ≥ N_FUNC.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  terminate the sweep; return to IDLE.
- `loop_en`  in  1  sampled at end of sweep; 1 restarts the sweep.
- `two_op_mask`  in  N_FUNC  bit f=1 means function f takes two operands.
- `tbl_we`  in  1  table write strobe; ignored while `busy`.
- `tbl_addr`  in  clog2(N_OPS)  table write address.
- `tbl_din`  in  2W  {op1, op2}.
- `sw_out`  out  W  value presented to CORDIC `sw_in`.
- `st`  out  1  one-cycle phase strobe to CORDIC `st`.
- `func_idx`  out  FW  current function code.
- `op_idx`  out  clog2(N_OPS)  current table entry.
- `busy`  out  1  high from the cycle after `start` until the sweep ends.
- `done`  out  1  one-cycle pulse at the end of each sweep.

## Operation
- States: IDLE, F, E1, E2, GO, RESULT (3-bit encoding).
- IDLE + `start` → F with `func_idx`=0 and `op_idx`=0.
- F: `sw_out` = zero-extended `func_idx`. E1: `sw_out` = op1[`op_idx`]. E2: `sw_out` = op2[`op_idx`]. GO and RESULT: `sw_out` holds its previous value.
- Order: F → E1 → (E2 if `two_op_mask[func_idx]`, else skipped) → GO → RESULT.
- RESULT exit:
  - `op_idx` < N_OPS-1: increment `op_idx`, go to F.
  - Else `func_idx` < N_FUNC-1: clear `op_idx`, increment `func_idx`, go to F.
  - Else end of sweep: pulse `done`. If `loop_en`=1, clear both indices and go to F with `busy` held high. Otherwise go to IDLE with `busy` low.
- `abort` takes priority over all transitions. The next state is IDLE, `st`=0, no `done`, and `sw_out` holds.
- `start` while `busy` is ignored.
- Table writes happen only in IDLE, one entry per cycle. The table is not reset; contents are undefined until written.

## Timing
- Reset values: `sw_out`=0, `st`=0, `busy`=0, `done`=0, `func_idx`=0, `op_idx`=0, state IDLE, dwell counter 0.
- Each phase lasts exactly WAIT_CNT+1 cycles. The counter runs 0..WAIT_CNT.
  - `sw_out` updates on the phase's first cycle.
  - `st`=1 only on the cycle where counter==WAIT_CNT.
  - The next phase starts the following cycle with the counter at 0.
- Latency: `start` sampled at edge k. The F phase and `busy`=1 begin at k+1. The first `st` occurs at k+1+WAIT_CNT.
- Operation length: 5·(WAIT_CNT+1) cycles for two-op functions, 4·(WAIT_CNT+1) for one-op functions.
- `done` is high in the cycle after the final RESULT `st`. `busy` falls in that same cycle unless looping.
- `abort` and the final `st` in the same cycle: abort wins, and `done` is not asserted.
- Asynchronous `rst` mid-sweep forces all reset values immediately.

## Structure
- Package `cordic_seq_pkg` contains:
  - state encodings;
  - the default two-op mask (functions 0, 1, 7 → 9'b010000011);
  - the `clog2` helper.
- Sub-module `phase_timer` (parameter WAIT_CNT) provides:
  - inputs `clr` and `en`;
  - output `expired` (counter==WAIT_CNT).
- Table storage is a 2W×N_OPS register array inside the top module.

## Test plan
- Reset: assert `rst` mid-F phase → all outputs at their reset values in the same cycle; state IDLE.
- Single two-op step: WAIT_CNT=3, N_OPS=1, N_FUNC=1, mask=1, table[0]={0x4000,0x2A9B} → `sw_out` sequence 0x0000, 0x4000, 0x2A9B with `st` at cycles 4, 8, 12, 16, 20; `done` at cycle 21.
- One-op skip: same setup, mask=0 → no 0x2A9B phase; four `st` pulses; `done` at cycle 17.
- Full sweep: defaults with WAIT_CNT=3, 8 entries, default mask →
  - `func_idx` steps 0..8;
  - `op_idx` wraps at 7;
  - exactly 3·8·5 + 6·8·4 = 312 `st` pulses, then one `done`.
- Abort: `abort` during E1 of entry 2 → IDLE next cycle, `st`=0, no `done`, `sw_out` held; a subsequent `start` restarts at func 0, entry 0.
- Loop and gating:
  - `loop_en`=1 → `done` pulses, `busy` stays high, and F restarts with `func_idx`=0.
  - `tbl_we` while `busy` → table unchanged.
  - `start` while `busy` → ignored.
